// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM arbiter.
// Optional feature macro used by this codebase slice: SRAM_ARB_PRIORITY_EN.
package sram_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } sram_arb_state_t;

  localparam int SRAM_ADDR_W = 18;
  localparam int SRAM_DATA_W = 16;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

endpackage

// File: rtl/rr_select.sv
// Next-winner selection: first set req bit at or after rr_ptr, with wraparound.
// With SRAM_ARB_PRIORITY_EN defined, requester 0 wins whenever it requests and
// the remaining requesters stay round-robin among themselves.
module rr_select #(
  parameter int NUM_REQ = 2,
  parameter int PTR_W   = 1
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   rr_ptr,
  output logic               any_req,
  output logic [PTR_W-1:0]   win_idx
);

  logic [PTR_W:0] cand;

  // Scan from rr_ptr upward; the first requesting slot found wins.
  always_comb begin
    any_req = 1'b0;
    win_idx = '0;
    cand    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = {1'b0, rr_ptr} + (PTR_W+1)'(k);
      if (cand >= (PTR_W+1)'(NUM_REQ)) begin
        cand = cand - (PTR_W+1)'(NUM_REQ);
      end
      if (!any_req && req[cand[PTR_W-1:0]]) begin
        any_req = 1'b1;
        win_idx = cand[PTR_W-1:0];
      end
    end
`ifdef SRAM_ARB_PRIORITY_EN
    if (req[0]) begin
      any_req = 1'b1;
      win_idx = '0;
    end
`else
`endif
  end

endmodule

// File: rtl/sram_arbiter.sv
// Round-robin arbiter sharing one SRAM controller user port among NUM_REQ
// clients. Optional macro: SRAM_ARB_PRIORITY_EN (requester 0 always wins).
//
// Controller handshake: the arbiter raises exactly one of ctl_read_en /
// ctl_wr_en and holds it, with ctl_addr/ctl_wdata stable, until the matching
// ctl_*_valid is sampled high; the enable drops on the following cycle, when
// done pulses. No new enable is issued until both ctl_*_busy are low.
module sram_arbiter
  import sram_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ADDR_W  = SRAM_ADDR_W,
  parameter int DATA_W  = SRAM_DATA_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        req_wr,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [DATA_W-1:0]         rdata,
  output logic                      ctl_read_en,
  output logic                      ctl_wr_en,
  output logic [ADDR_W-1:0]         ctl_addr,
  output logic [DATA_W-1:0]         ctl_wdata,
  input  logic [DATA_W-1:0]         ctl_rdata,
  input  logic                      ctl_read_valid,
  input  logic                      ctl_wr_valid,
  input  logic                      ctl_read_busy,
  input  logic                      ctl_wr_busy,
  output sram_arb_state_t           dbg_state
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  sram_arb_state_t    state, state_d;
  logic [PTR_W-1:0]   rr_ptr, rr_ptr_d;
  logic [PTR_W-1:0]   cur_idx, cur_idx_d;
  logic [PTR_W-1:0]   sel_idx;
  logic               sel_valid;
  logic [NUM_REQ-1:0] gnt_d, done_d;
  logic [DATA_W-1:0]  rdata_d;
  logic               rd_en_d, wr_en_d;
  logic [ADDR_W-1:0]  op_addr, op_addr_d, win_addr;
  logic [DATA_W-1:0]  op_wdata, op_wdata_d, win_wdata;
  logic               op_wr, op_wr_d, win_wr;
  logic               op_valid;

  rr_select #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_select (
    .req     (req),
    .rr_ptr  (rr_ptr),
    .any_req (sel_valid),
    .win_idx (sel_idx)
  );

  // Pick out the selected requester's address, data and operation.
  always_comb begin
    win_addr  = '0;
    win_wdata = '0;
    win_wr    = OP_READ;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (sel_idx == PTR_W'(i)) begin
        win_addr  = req_addr[i*ADDR_W +: ADDR_W];
        win_wdata = req_wdata[i*DATA_W +: DATA_W];
        win_wr    = req_wr[i];
      end
    end
  end

  assign op_valid = (op_wr == OP_WRITE) ? ctl_wr_valid : ctl_read_valid;

  // Next-state and next-output logic; every registered output is computed here.
  always_comb begin
    state_d    = state;
    rr_ptr_d   = rr_ptr;
    cur_idx_d  = cur_idx;
    gnt_d      = gnt;
    done_d     = '0;
    rdata_d    = rdata;
    rd_en_d    = ctl_read_en;
    wr_en_d    = ctl_wr_en;
    op_addr_d  = op_addr;
    op_wdata_d = op_wdata;
    op_wr_d    = op_wr;
    case (state)
      ST_IDLE: begin
        if (sel_valid) begin
          cur_idx_d  = sel_idx;
          gnt_d      = NUM_REQ'(1) << sel_idx;
          op_addr_d  = win_addr;
          op_wdata_d = win_wdata;
          op_wr_d    = win_wr;
          rd_en_d    = (win_wr == OP_READ);
          wr_en_d    = (win_wr == OP_WRITE);
          state_d    = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (op_valid) begin
          rd_en_d  = 1'b0;
          wr_en_d  = 1'b0;
          done_d   = gnt;
          if (op_wr == OP_READ) begin
            rdata_d = ctl_rdata;
          end
          rr_ptr_d = (cur_idx == PTR_W'(NUM_REQ-1)) ? '0 : cur_idx + PTR_W'(1);
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (!ctl_read_busy && !ctl_wr_busy) begin
          gnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered outputs, cleared by the shared synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      rr_ptr      <= '0;
      cur_idx     <= '0;
      gnt         <= '0;
      done        <= '0;
      rdata       <= '0;
      ctl_read_en <= 1'b0;
      ctl_wr_en   <= 1'b0;
      op_addr     <= '0;
      op_wdata    <= '0;
      op_wr       <= OP_READ;
    end else begin
      state       <= state_d;
      rr_ptr      <= rr_ptr_d;
      cur_idx     <= cur_idx_d;
      gnt         <= gnt_d;
      done        <= done_d;
      rdata       <= rdata_d;
      ctl_read_en <= rd_en_d;
      ctl_wr_en   <= wr_en_d;
      op_addr     <= op_addr_d;
      op_wdata    <= op_wdata_d;
      op_wr       <= op_wr_d;
    end
  end

  assign ctl_addr  = op_addr;
  assign ctl_wdata = op_wdata;
  assign dbg_state = state;

endmodule

// File: tb/tb_sram_arbiter.sv
// Bench for sram_arbiter: SRAM controller model, round-robin reference model,
// directed scenarios plus randomized transactions.
module tb_sram_arbiter;
  import sram_pkg::*;

  localparam int N  = 2;
  localparam int AW = 18;
  localparam int DW = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_wr = '0;
  logic [N*AW-1:0] req_addr = '0;
  logic [N*DW-1:0] req_wdata = '0;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata;
  logic            ctl_read_en, ctl_wr_en;
  logic [AW-1:0]   ctl_addr;
  logic [DW-1:0]   ctl_wdata;
  logic [DW-1:0]   ctl_rdata = '0;
  logic            ctl_read_valid = 1'b0, ctl_wr_valid = 1'b0;
  logic            ctl_read_busy = 1'b0, ctl_wr_busy = 1'b0;
  sram_arb_state_t dbg_state;

  int tests = 0;
  int fails = 0;

  sram_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_wr(req_wr), .req_addr(req_addr),
    .req_wdata(req_wdata), .gnt(gnt), .done(done), .rdata(rdata),
    .ctl_read_en(ctl_read_en), .ctl_wr_en(ctl_wr_en), .ctl_addr(ctl_addr),
    .ctl_wdata(ctl_wdata), .ctl_rdata(ctl_rdata), .ctl_read_valid(ctl_read_valid),
    .ctl_wr_valid(ctl_wr_valid), .ctl_read_busy(ctl_read_busy),
    .ctl_wr_busy(ctl_wr_busy), .dbg_state(dbg_state)
  );

  // ---------------- reference model state ----------------
  logic [DW-1:0] mem [logic [AW-1:0]];
  int            model_ptr = 0;
  logic [DW-1:0] exp_rdata = '0;
  logic [7:0]    exp_q[$];

  function automatic logic [DW-1:0] mem_read(input logic [AW-1:0] a);
    if (mem.exists(a)) return mem[a];
    return a[DW-1:0] ^ 16'h5A5A;
  endfunction

  // First requesting index at or after ptr, wrapping; requester 0 first when prioritised.
  function automatic int ref_pick(input logic [N-1:0] r, input int ptr);
`ifdef SRAM_ARB_PRIORITY_EN
    if (r[0]) return 0;
`else
`endif
    for (int k = 0; k < N; k++) begin
      if (r[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  function automatic logic [N-1:0] onehot(input int i);
    logic [N-1:0] v;
    v = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  // ---------------- controller model ----------------
  int cfg_lat = 1;
  int cfg_busy = 0;
  int wait_cnt = 0;
  int busy_left = 0;
  bit given = 1'b0;
  bit cur_wr = 1'b0;

  always @(negedge clk) begin
    ctl_read_valid = 1'b0;
    ctl_wr_valid   = 1'b0;
    if (rst) begin
      wait_cnt = 0; busy_left = 0; given = 1'b0; cur_wr = 1'b0;
      ctl_read_busy = 1'b0; ctl_wr_busy = 1'b0; ctl_rdata = '0;
    end else begin
      if (busy_left > 0) busy_left--;
      if (!(ctl_read_en || ctl_wr_en)) begin
        given = 1'b0;
        wait_cnt = 0;
      end else if (!given) begin
        if (wait_cnt >= cfg_lat) begin
          given = 1'b1;
          busy_left = cfg_busy;
          cur_wr = ctl_wr_en;
          if (ctl_wr_en) begin
            ctl_wr_valid = 1'b1;
            mem[ctl_addr] = ctl_wdata;
          end else begin
            ctl_read_valid = 1'b1;
            ctl_rdata = mem_read(ctl_addr);
          end
        end else begin
          wait_cnt++;
        end
      end
      ctl_read_busy = (busy_left > 0) && !cur_wr;
      ctl_wr_busy   = (busy_left > 0) && cur_wr;
    end
  end

  // Structural invariants checked every cycle.
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      tests++;
      if ((ctl_read_en && ctl_wr_en) || ((ctl_read_en || ctl_wr_en) && gnt == '0) ||
          !$onehot0(gnt) || !$onehot0(done)) begin
        fails++;
        $display("FAIL invariant: rd_en=%b wr_en=%b gnt=%b done=%b", ctl_read_en, ctl_wr_en, gnt, done);
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (gnt != '0 && (ctl_read_en || ctl_wr_en)) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic wait_done(output bit ok, output bit valid_now);
    ok = 1'b0;
    valid_now = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (done != '0) begin
        ok = 1'b1;
        valid_now = ctl_read_valid || ctl_wr_valid;
      end
    end
  endtask

  task automatic wait_idle(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (gnt == '0) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    rst = 1'b0;
    model_ptr = 0;
    exp_rdata = '0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    req = '0;
    tick();
    tick();
    tests++;
    if ({gnt, done, rdata, ctl_read_en, ctl_wr_en, ctl_addr, ctl_wdata} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: gnt=%b done=%b rdata=%h en=%b%b addr=%h wdata=%h expected all 0",
               gnt, done, rdata, ctl_read_en, ctl_wr_en, ctl_addr, ctl_wdata);
    end
    tests++;
    if (dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL reset_state: got %0d expected %0d", dbg_state, ST_IDLE);
    end
    rst = 1'b0;
    model_ptr = 0;
    exp_rdata = '0;
    tick();
  endtask

  task automatic test_single_read();
    bit ok, vn;
    cfg_lat = 2; cfg_busy = 0;
    mem[18'h00123] = 16'hBEEF;
    req_wr = '0;
    req_addr[1*AW +: AW] = 18'h00123;
    req = 2'b10;
    tick();
    tests++;
    if (gnt !== 2'b10 || ctl_read_en !== 1'b1 || ctl_wr_en !== 1'b0 || ctl_addr !== 18'h00123) begin
      fails++;
      $display("FAIL read_issue: gnt=%b rd=%b wr=%b addr=%h expected 10 1 0 00123", gnt, ctl_read_en, ctl_wr_en, ctl_addr);
    end
    req = '0;
    wait_done(ok, vn);
    tests++;
    if (!ok || done !== 2'b10 || !vn || ctl_read_en !== 1'b0) begin
      fails++;
      $display("FAIL read_done: ok=%b done=%b valid_same_sample=%b rd=%b expected 1 10 1 0", ok, done, vn, ctl_read_en);
    end
    tests++;
    if (rdata !== 16'hBEEF) begin
      fails++;
      $display("FAIL read_rdata: got %h expected beef", rdata);
    end
    exp_rdata = 16'hBEEF;
    model_ptr = (1 + 1) % N;
    tick();
    tests++;
    if (done !== '0 || rdata !== exp_rdata) begin
      fails++;
      $display("FAIL read_pulse: done=%b rdata=%h expected 0 %h", done, rdata, exp_rdata);
    end
    wait_idle(ok);
  endtask

  task automatic test_single_write();
    bit ok, vn, rd_seen;
    cfg_lat = 1; cfg_busy = 0;
    req_wr = 2'b01;
    req_addr[0 +: AW] = 18'h3FFFF;
    req_wdata[0 +: DW] = 16'hA5A5;
    req = 2'b01;
    tick();
    tests++;
    if (gnt !== 2'b01 || ctl_wr_en !== 1'b1 || ctl_read_en !== 1'b0 ||
        ctl_addr !== 18'h3FFFF || ctl_wdata !== 16'hA5A5) begin
      fails++;
      $display("FAIL write_issue: gnt=%b wr=%b rd=%b addr=%h wdata=%h expected 01 1 0 3ffff a5a5",
               gnt, ctl_wr_en, ctl_read_en, ctl_addr, ctl_wdata);
    end
    req = '0;
    rd_seen = 1'b0;
    ok = 1'b0;
    vn = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      tick();
      if (ctl_read_en) rd_seen = 1'b1;
      if (done != '0) begin
        ok = 1'b1;
        vn = ctl_wr_valid;
      end
    end
    tests++;
    if (!ok || done !== 2'b01 || !vn || rd_seen || ctl_wr_en !== 1'b0) begin
      fails++;
      $display("FAIL write_done: ok=%b done=%b valid_same_sample=%b rd_seen=%b wr=%b expected 1 01 1 0 0",
               ok, done, vn, rd_seen, ctl_wr_en);
    end
    tests++;
    if (mem_read(18'h3FFFF) !== 16'hA5A5 || rdata !== exp_rdata) begin
      fails++;
      $display("FAIL write_data: mem=%h rdata=%h expected a5a5 %h", mem_read(18'h3FFFF), rdata, exp_rdata);
    end
    model_ptr = (0 + 1) % N;
    wait_idle(ok);
  endtask

  task automatic test_late_change();
    bit ok, vn;
    logic [DW-1:0] exp_rd;
    cfg_lat = 3; cfg_busy = 0;
    req_wr = '0;
    req_addr[0 +: AW] = 18'h00010;
    exp_rd = mem_read(18'h00010);
    req = 2'b01;
    tick();
    tests++;
    if (gnt !== 2'b01 || ctl_addr !== 18'h00010) begin
      fails++;
      $display("FAIL late_grant: gnt=%b addr=%h expected 01 00010", gnt, ctl_addr);
    end
    req = '0;
    req_addr[0 +: AW] = 18'h00001;
    req_wr[0] = 1'b1;
    req_wdata[0 +: DW] = DW'($urandom);
    for (int i = 0; i < 3; i++) begin
      tick();
      tests++;
      if (ctl_addr !== 18'h00010 || ctl_read_en !== 1'b1 || ctl_wr_en !== 1'b0) begin
        fails++;
        $display("FAIL late_hold: addr=%h rd=%b wr=%b expected 00010 1 0", ctl_addr, ctl_read_en, ctl_wr_en);
      end
    end
    wait_done(ok, vn);
    tests++;
    if (!ok || done !== 2'b01 || !vn || rdata !== exp_rd) begin
      fails++;
      $display("FAIL late_done: ok=%b done=%b valid=%b rdata=%h expected 1 01 1 %h", ok, done, vn, rdata, exp_rd);
    end
    exp_rdata = exp_rd;
    model_ptr = 1 % N;
    wait_idle(ok);
  endtask

  task automatic test_random();
    bit ok, vn;
    int w;
    logic [N-1:0]  r;
    logic [AW-1:0] a;
    logic [DW-1:0] d, exp_rd;
    logic          is_wr;
    for (int it = 0; it < 24; it++) begin
      wait_idle(ok);
      cfg_lat = $urandom_range(0, 3);
      cfg_busy = $urandom_range(0, 3);
      r = N'($urandom_range(1, (1 << N) - 1));
      for (int i = 0; i < N; i++) begin
        req_wr[i] = 1'($urandom);
        req_addr[i*AW +: AW] = AW'($urandom_range(0, 63));
        req_wdata[i*DW +: DW] = DW'($urandom);
      end
      w = ref_pick(r, model_ptr);
      a = req_addr[w*AW +: AW];
      d = req_wdata[w*DW +: DW];
      is_wr = req_wr[w];
      exp_rd = mem_read(a);
      req = r;
      tick();
      tests++;
      if (gnt !== onehot(w) || ctl_addr !== a || ctl_wr_en !== is_wr || ctl_read_en !== !is_wr ||
          (is_wr && ctl_wdata !== d)) begin
        fails++;
        $display("FAIL rand_grant it=%0d: gnt=%b addr=%h wr=%b rd=%b wdata=%h expected %b %h %b %b %h",
                 it, gnt, ctl_addr, ctl_wr_en, ctl_read_en, ctl_wdata, onehot(w), a, is_wr, !is_wr, d);
      end
      req = '0;
      for (int i = 0; i < N; i++) begin
        req_wr[i] = 1'($urandom);
        req_addr[i*AW +: AW] = AW'($urandom);
      end
      wait_done(ok, vn);
      if (!is_wr) exp_rdata = exp_rd;
      tests++;
      if (!ok || done !== onehot(w) || !vn || rdata !== exp_rdata || (is_wr && mem_read(a) !== d)) begin
        fails++;
        $display("FAIL rand_done it=%0d: ok=%b done=%b valid=%b rdata=%h mem=%h expected 1 %b 1 %h %h",
                 it, ok, done, vn, rdata, mem_read(a), onehot(w), exp_rdata, d);
      end
      model_ptr = (w + 1) % N;
    end
    wait_idle(ok);
    cfg_busy = 0;
  endtask

  task automatic test_contention();
    bit ok, vn;
    int p, w, g;
    logic [DW-1:0] exp_rd;
    do_reset();
    cfg_lat = 1; cfg_busy = 0;
    for (int i = 0; i < N; i++) begin
      req_wr[i] = 1'($urandom);
      req_addr[i*AW +: AW] = AW'($urandom_range(64, 127));
      req_wdata[i*DW +: DW] = DW'($urandom);
    end
    p = model_ptr;
    for (int k = 0; k < 4; k++) begin
      w = ref_pick(2'b11, p);
      exp_q.push_back(8'(w));
      p = (w + 1) % N;
    end
    req = 2'b11;
    for (int t = 0; t < 4; t++) begin
      wait_gnt(ok);
      w = int'(exp_q.pop_front());
      exp_rd = mem_read(req_addr[w*AW +: AW]);
      tests++;
      if (!ok || gnt !== onehot(w)) begin
        fails++;
        $display("FAIL contention_order t=%0d: ok=%b gnt=%b expected %b", t, ok, gnt, onehot(w));
      end
      wait_done(ok, vn);
      if (!req_wr[w]) exp_rdata = exp_rd;
      tests++;
      if (!ok || done !== onehot(w) || rdata !== exp_rdata) begin
        fails++;
        $display("FAIL contention_done t=%0d: ok=%b done=%b rdata=%h expected 1 %b %h", t, ok, done, rdata, onehot(w), exp_rdata);
      end
      if (t < 3) begin
        g = 0;
        for (int i = 0; i < 20 && !(ctl_read_en || ctl_wr_en); i++) begin
          tick();
          g++;
        end
        tests++;
        if (g != 2) begin
          fails++;
          $display("FAIL contention_gap t=%0d: done-to-enable %0d cycles expected 2", t, g);
        end
      end else begin
        req = '0;
      end
    end
    model_ptr = p;
    wait_idle(ok);
  endtask

  task automatic test_drain_hold();
    bit ok, vn, en_busy;
    int low_at, en_at;
    logic [DW-1:0] exp_rd;
    cfg_lat = 1; cfg_busy = 12;
    req_wr = '0;
    req_addr[1*AW +: AW] = 18'h00200;
    exp_rd = mem_read(18'h00200);
    req = 2'b10;
    wait_gnt(ok);
    wait_done(ok, vn);
    exp_rdata = exp_rd;
    tests++;
    if (!ok || done !== 2'b10 || rdata !== exp_rdata) begin
      fails++;
      $display("FAIL drain_done: ok=%b done=%b rdata=%h expected 1 10 %h", ok, done, rdata, exp_rdata);
    end
    low_at = -1; en_at = -1; en_busy = 1'b0;
    for (int c = 1; c <= 40 && en_at < 0; c++) begin
      tick();
      if (!ctl_read_busy && low_at < 0) low_at = c;
      if (ctl_read_en || ctl_wr_en) begin
        en_at = c;
        if (low_at < 0) en_busy = 1'b1;
      end
    end
    tests++;
    if (en_busy || en_at != 13 || en_at != low_at + 1) begin
      fails++;
      $display("FAIL drain_hold: enable at %0d busy low at %0d early=%b expected 13 12 0", en_at, low_at, en_busy);
    end
    tests++;
    if (gnt !== 2'b10) begin
      fail_msg: begin
        fails++;
        $display("FAIL drain_regrant: gnt=%b expected 10", gnt);
      end
    end
    req = '0;
    wait_done(ok, vn);
    model_ptr = (1 + 1) % N;
    wait_idle(ok);
    cfg_busy = 0;
  endtask

  task automatic test_reset_mid_issue();
    bit ok, vn;
    logic [DW-1:0] exp_rd;
    cfg_lat = 10; cfg_busy = 0;
    req_wr = '0;
    req_addr[1*AW +: AW] = 18'h00333;
    req_addr[0 +: AW] = 18'h00044;
    req = 2'b10;
    tick();
    tick();
    tick();
    tick();
    rst = 1'b1;
    tick();
    tests++;
    if ({gnt, done, rdata, ctl_read_en, ctl_wr_en, ctl_addr, ctl_wdata} !== '0 || dbg_state !== ST_IDLE) begin
      fails++;
      $display("FAIL midreset_outputs: gnt=%b done=%b rdata=%h en=%b%b addr=%h expected all 0",
               gnt, done, rdata, ctl_read_en, ctl_wr_en, ctl_addr);
    end
    req = 2'b11;
    tick();
    tests++;
    if (done !== '0 || gnt !== '0) begin
      fails++;
      $display("FAIL midreset_hold: done=%b gnt=%b expected 0 0", done, gnt);
    end
    rst = 1'b0;
    model_ptr = 0;
    exp_rdata = '0;
    cfg_lat = 1;
    exp_rd = mem_read(18'h00044);
    tick();
    tests++;
    if (gnt !== onehot(ref_pick(2'b11, model_ptr)) || gnt !== 2'b01) begin
      fails++;
      $display("FAIL midreset_regrant: gnt=%b expected 01", gnt);
    end
    req = '0;
    wait_done(ok, vn);
    exp_rdata = exp_rd;
    tests++;
    if (!ok || done !== 2'b01 || rdata !== exp_rdata) begin
      fails++;
      $display("FAIL midreset_done: ok=%b done=%b rdata=%h expected 1 01 %h", ok, done, rdata, exp_rdata);
    end
    model_ptr = 1 % N;
    wait_idle(ok);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_read();
    test_single_write();
    test_late_change();
    test_random();
    test_contention();
    test_drain_hold();
    test_reset_mid_issue();
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    fails++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $fatal(1, "watchdog expired");
  end

endmodule
